// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported RAM between an instruction-fetch port and a
//   data (LDR/STR) port.
//   - At most one access is granted per cycle.
//   - Data has priority over fetch.
//   - After three consecutive data grants while fetch waits, fetch wins once.
//   - Read data arrives one cycle after the grant. Each response is tagged
//     by a small FSM, so a new access can be granted in every cycle.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   if_req/if_addr                fetch request and byte address
//   if_gnt                        fetch granted this cycle (combinational)
//   if_valid/if_rdata             fetch response (one cycle after grant)
//   d_req/d_we/d_addr/d_wdata     data request (d_we=1: store)
//   d_gnt                         data granted this cycle (combinational)
//   d_valid/d_rdata               data response (read data, or 0 for store ack)
//   sel_stall                     some pending request was not granted
//   mem_addr/mem_w_en/mem_wdata   RAM word address, write enable, write data
//   mem_rdata                     RAM read data, valid one cycle after address
module mem_port_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_valid,
  output logic [31:0] d_rdata,
  output logic        sel_stall,
  output logic [9:0]  mem_addr,
  output logic        mem_w_en,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] IF_RESP = 2'd1;
  localparam logic [1:0] D_RESP  = 2'd2;

  logic [1:0] state;
  logic [1:0] d_streak;
  logic       wr_q;     // the access behind the D_RESP response is a store

  // Fetch preempts data only once data has won three times in a row while
  // fetch was waiting. Grants are forced low during reset, which also keeps
  // any access requested in a reset cycle from producing a response.
  logic fetch_turn;
  assign fetch_turn = if_req && (d_streak == 2'd3);
  assign d_gnt      = !rst && d_req && !fetch_turn;
  assign if_gnt     = !rst && if_req && !(d_req && !fetch_turn);
  assign sel_stall  = (if_req && !if_gnt) || (d_req && !d_gnt);

  assign mem_addr  = d_gnt ? d_addr[11:2] : (if_gnt ? if_addr[11:2] : 10'd0);
  assign mem_w_en  = d_gnt && d_we;
  assign mem_wdata = d_gnt ? d_wdata : 32'd0;

  // Byte-offset and upper address bits are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:12], if_addr[1:0],
                              d_addr[31:12], d_addr[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      d_streak <= 2'd0;
    end else if (if_gnt || !if_req) begin
      d_streak <= 2'd0;
    end else if (d_gnt && d_streak != 2'd3) begin
      d_streak <= d_streak + 2'd1;
    end
  end

  // The response state is taken only from this cycle's grant. A response
  // being delivered therefore never blocks the next grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wr_q  <= 1'b0;
    end else begin
      wr_q <= d_gnt && d_we;
      if (if_gnt)     state <= IF_RESP;
      else if (d_gnt) state <= D_RESP;
      else            state <= IDLE;
    end
  end

  assign if_valid = (state == IF_RESP);
  assign if_rdata = if_valid ? mem_rdata : 32'd0;
  assign d_valid  = (state == D_RESP);
  assign d_rdata  = (d_valid && !wr_q) ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic        if_gnt, if_valid, d_gnt, d_valid, sel_stall, mem_w_en;
  logic [31:0] if_rdata, d_rdata, mem_wdata;
  logic [31:0] mem_rdata = 32'd0;
  logic [9:0]  mem_addr;
  logic [31:0] ram [0:1023];
  int tests = 0;
  int fails = 0;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
    .sel_stall(sel_stall), .mem_addr(mem_addr), .mem_w_en(mem_w_en),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // RAM model: word i initially holds A000_0000 + i, read latency one cycle.
  initial for (int i = 0; i < 1024; i++) ram[i] = 32'hA000_0000 + i;
  always @(posedge clk) begin
    if (mem_w_en) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its end");
    $fatal(1, "timeout");
  end

  task automatic drive(input logic r, input logic ir, input logic [31:0] ia,
                       input logic dr, input logic we, input logic [31:0] da,
                       input logic [31:0] wd);
    @(negedge clk);
    rst = r; if_req = ir; if_addr = ia; d_req = dr; d_we = we;
    d_addr = da; d_wdata = wd;
    #1;
  endtask

  task automatic idle_cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    drive(1, 1, 32'h10, 1, 1, 32'h44, 32'h1234);
    tests++; if (if_gnt !== 1'b0 || d_gnt !== 1'b0 || mem_w_en !== 1'b0) begin
      fails++; $display("FAIL rst_gnt: if_gnt=%b d_gnt=%b w_en=%b want 0 0 0", if_gnt, d_gnt, mem_w_en); end
    @(posedge clk); #1;
    tests++; if (if_valid !== 1'b0 || d_valid !== 1'b0) begin
      fails++; $display("FAIL rst_valid: if_valid=%b d_valid=%b want 0 0", if_valid, d_valid); end
    tests++; if (dut.d_streak !== 2'd0 || dut.state !== 2'd0) begin
      fails++; $display("FAIL rst_state: streak=%0d state=%0d want 0 0", dut.d_streak, dut.state); end
  endtask

  task automatic test_idle();
    drive(0, 0, 32'h10, 0, 1, 32'h44, 32'h55);
    tests++; if ({if_gnt, d_gnt, sel_stall, mem_w_en} !== 4'b0 || mem_addr !== 10'd0 || mem_wdata !== 32'd0) begin
      fails++; $display("FAIL idle: gi=%b gd=%b stall=%b wen=%b addr=%0d wd=%h want all 0",
                        if_gnt, d_gnt, sel_stall, mem_w_en, mem_addr, mem_wdata); end
    @(posedge clk); #1;
    tests++; if (if_valid !== 1'b0 || d_valid !== 1'b0) begin
      fails++; $display("FAIL idle_valid: if_valid=%b d_valid=%b want 0 0", if_valid, d_valid); end
  endtask

  task automatic test_single_fetch();
    drive(0, 1, 32'h0000_0010, 0, 0, 0, 0);
    tests++; if (if_gnt !== 1'b1 || d_gnt !== 1'b0 || mem_addr !== 10'd4 || sel_stall !== 1'b0) begin
      fails++; $display("FAIL fetch_gnt: gi=%b gd=%b addr=%0d stall=%b want 1 0 4 0", if_gnt, d_gnt, mem_addr, sel_stall); end
    @(posedge clk); #1;
    tests++; if (if_valid !== 1'b1 || if_rdata !== 32'hA000_0004 || d_valid !== 1'b0) begin
      fails++; $display("FAIL fetch_resp: v=%b data=%h dv=%b want 1 a0000004 0", if_valid, if_rdata, d_valid); end
    idle_cycle();
  endtask

  task automatic test_simultaneous();
    drive(0, 1, 32'h10, 1, 0, 32'h20, 0);
    tests++; if (d_gnt !== 1'b1 || if_gnt !== 1'b0 || sel_stall !== 1'b1 || mem_addr !== 10'd8) begin
      fails++; $display("FAIL simul_gnt: gd=%b gi=%b stall=%b addr=%0d want 1 0 1 8", d_gnt, if_gnt, sel_stall, mem_addr); end
    @(posedge clk); #1;
    tests++; if (d_valid !== 1'b1 || d_rdata !== 32'hA000_0008 || if_valid !== 1'b0) begin
      fails++; $display("FAIL simul_resp: dv=%b data=%h iv=%b want 1 a0000008 0", d_valid, d_rdata, if_valid); end
    idle_cycle();
  endtask

  task automatic test_starvation();
    logic       exp_d [5] = '{1, 1, 1, 0, 1};
    logic [1:0] exp_s [5] = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 32'h10, 1, 0, 32'h20, 0);
      tests++; if (d_gnt !== exp_d[i] || if_gnt !== !exp_d[i] || dut.d_streak !== exp_s[i]) begin
        fails++; $display("FAIL starve[%0d]: gd=%b gi=%b streak=%0d want %b %b %0d",
                          i, d_gnt, if_gnt, dut.d_streak, exp_d[i], !exp_d[i], exp_s[i]); end
      @(posedge clk);
    end
    idle_cycle();
  endtask

  task automatic test_store();
    drive(0, 0, 0, 1, 1, 32'h44, 32'hDEAD_BEEF);
    tests++; if (mem_w_en !== 1'b1 || mem_addr !== 10'h11 || mem_wdata !== 32'hDEAD_BEEF || d_gnt !== 1'b1) begin
      fails++; $display("FAIL store_gnt: wen=%b addr=%h wd=%h gd=%b want 1 11 deadbeef 1", mem_w_en, mem_addr, mem_wdata, d_gnt); end
    @(posedge clk); #1;
    tests++; if (d_valid !== 1'b1 || d_rdata !== 32'd0) begin
      fails++; $display("FAIL store_ack: dv=%b data=%h want 1 0", d_valid, d_rdata); end
    // Load the stored word back immediately.
    drive(0, 0, 0, 1, 0, 32'h44, 32'h0);
    tests++; if (mem_w_en !== 1'b0 || mem_wdata !== 32'd0) begin
      fails++; $display("FAIL load_wen: wen=%b wd=%h want 0 0", mem_w_en, mem_wdata); end
    @(posedge clk); #1;
    tests++; if (d_valid !== 1'b1 || d_rdata !== 32'hDEAD_BEEF) begin
      fails++; $display("FAIL load_back: dv=%b data=%h want 1 deadbeef", d_valid, d_rdata); end
    idle_cycle();
  endtask

  task automatic test_reset_mid();
    drive(0, 1, 32'h10, 1, 0, 32'h20, 0);
    @(posedge clk);
    drive(1, 1, 32'h10, 0, 0, 0, 0);
    tests++; if (if_gnt !== 1'b0) begin
      fails++; $display("FAIL rstmid_gnt: gi=%b want 0", if_gnt); end
    @(posedge clk); #1;
    tests++; if (if_valid !== 1'b0 || d_valid !== 1'b0 || dut.state !== 2'd0 || dut.d_streak !== 2'd0) begin
      fails++; $display("FAIL rstmid: iv=%b dv=%b state=%0d streak=%0d want 0 0 0 0",
                        if_valid, d_valid, dut.state, dut.d_streak); end
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] addr [4] = '{32'h10, 32'h20, 32'h30, 32'h40};
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) drive(0, 1, addr[i], 0, 0, 0, 0);
      else            drive(0, 0, 0, 1, 0, addr[i], 0);
      tests++; if (mem_addr !== addr[i][11:2] || (if_gnt | d_gnt) !== 1'b1) begin
        fails++; $display("FAIL b2b_gnt[%0d]: addr=%0d gi=%b gd=%b want %0d", i, mem_addr, if_gnt, d_gnt, addr[i][11:2]); end
      @(posedge clk); #1;
      if (i % 2 == 0) begin
        tests++; if (if_valid !== 1'b1 || d_valid !== 1'b0 || if_rdata !== 32'hA000_0000 + addr[i][11:2]) begin
          fails++; $display("FAIL b2b_resp[%0d]: iv=%b dv=%b data=%h", i, if_valid, d_valid, if_rdata); end
      end else begin
        tests++; if (d_valid !== 1'b1 || if_valid !== 1'b0 || d_rdata !== 32'hA000_0000 + addr[i][11:2]) begin
          fails++; $display("FAIL b2b_resp[%0d]: iv=%b dv=%b data=%h", i, if_valid, d_valid, d_rdata); end
      end
    end
    idle_cycle();
    tests++; if (if_valid !== 1'b0 || d_valid !== 1'b0) begin
      fails++; $display("FAIL b2b_tail: iv=%b dv=%b want 0 0", if_valid, d_valid); end
  endtask

  initial begin
    rst = 1'b1; if_req = 0; d_req = 0; d_we = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0;
    test_reset();
    test_idle();
    test_single_fetch();
    test_simultaneous();
    test_starvation();
    test_store();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
